// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_pkg: shared state encoding and sizing helpers for the CPU
// trace buffer and its storage RAM.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Address width for a buffer of the given depth (never narrower than one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// trace_ram: simple dual-port sample store, one write port and one
// registered read port (1-cycle latency). The array itself has no reset;
// only the read register can be cleared so the readout bus starts at zero.
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
  input  logic                      rd_clr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Write port: the storage array keeps its contents across reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register next value: clear, load on read, otherwise hold
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_clr) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read register
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of NUM_CH x DATA_W channel samples
// around a trigger, with POST_TRIG samples kept after the trigger sample and
// oldest-first readout once capture is done.
// Optional build macro TRACE_CMP_TRIG_EN adds a TrigValue input; channel 0
// matching it counts as a trigger in addition to Trig.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Arm,
  input  logic                       SampleEn,
  input  logic [NUM_CH*DATA_W-1:0]   ChIn,
  input  logic                       Trig,
`ifdef TRACE_CMP_TRIG_EN
  input  logic [DATA_W-1:0]          TrigValue,
`endif
  input  logic                       RdEn,
  output logic [NUM_CH*DATA_W-1:0]   RdData,
  output logic                       RdValid,
  output logic [1:0]                 State,
  output logic                       Done,
  output logic                       Wrapped,
  output logic [ptr_w(DEPTH):0]      Count,
  output logic [ptr_w(DEPTH):0]      Remain
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] POST_INIT = PW'(POST_TRIG);

  trace_state_e  state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] post_cnt_q, post_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          wrapped_q, wrapped_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic          wr_en_s, rd_en_s;
  logic          trig_hit_s;
  logic          post_last_s;

`ifdef TRACE_CMP_TRIG_EN
  assign trig_hit_s = Trig | (ChIn[DATA_W-1:0] == TrigValue);
`else
  assign trig_hit_s = Trig;
`endif

  assign post_last_s = (post_cnt_q == PTR_ONE);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: Arm restarts from anywhere, trigger and post countdown advance capture
  always_comb begin
    state_d = state_q;
    if (Arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (SampleEn && trig_hit_s) begin
            state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          if (SampleEn && post_last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POST;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: Done follows the state being entered
  always_comb begin
    done_d = 1'b0;
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Capture side: write pointer, fill count, wrap flag, post-trigger countdown
  always_comb begin
    wr_en_s    = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    post_cnt_d = post_cnt_q;
    if (Arm) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      wrapped_d  = 1'b0;
      post_cnt_d = '0;
    end else if (((state_q == ST_ARMED) || (state_q == ST_POST)) && SampleEn) begin
      wr_en_s  = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == CNT_FULL) begin
        // Only overwriting while still waiting for the trigger loses pre-trigger history
        wrapped_d = wrapped_q | (state_q == ST_ARMED);
      end else begin
        count_d = count_q + CNT_ONE;
      end
      if (state_q == ST_POST) begin
        post_cnt_d = post_cnt_q - PTR_ONE;
      end else if (trig_hit_s) begin
        post_cnt_d = POST_INIT;
      end else begin
        post_cnt_d = post_cnt_q;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Readout side: load oldest pointer on DONE entry, step one entry per accepted read
  always_comb begin
    rd_en_s    = 1'b0;
    rd_valid_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    remain_d   = remain_q;
    if (Arm) begin
      rd_ptr_d = '0;
      remain_d = '0;
    end else if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      // A full buffer has count low bits of zero, so the oldest entry is at the write pointer
      rd_ptr_d = wr_ptr_d - count_d[PW-1:0];
      remain_d = count_d;
    end else if ((state_q == ST_DONE) && RdEn && (remain_q != '0)) begin
      rd_en_s    = 1'b1;
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      remain_d   = remain_q - CNT_ONE;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
      remain_q   <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      count_q    <= count_d;
      remain_q   <= remain_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (NUM_CH*DATA_W)
  ) u_trace_ram (
    .clk     (Clock),
    .wr_en   (wr_en_s & ~Reset),
    .wr_addr (wr_ptr_q),
    .wr_data (ChIn),
    .rd_en   (rd_en_s & ~Reset),
    .rd_addr (rd_ptr_q),
    .rd_clr  (Reset),
    .rd_data (RdData)
  );

  assign State   = state_q;
  assign Done    = done_q;
  assign Wrapped = wrapped_q;
  assign Count   = count_q;
  assign Remain  = remain_q;
  assign RdValid = rd_valid_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed table vectors, hand-written corner sequences
// and random stimulus checked against a queue-based reference model.
module tb_cpu_trace_buffer;

  localparam int DATA_W    = 8;
  localparam int NUM_CH    = 4;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 3;
  localparam int W         = NUM_CH*DATA_W;

  logic         Clock = 1'b0;
  logic         Reset, Arm, SampleEn, Trig, RdEn;
  logic [W-1:0] ChIn;
  logic [W-1:0] RdData;
  logic         RdValid, Done, Wrapped;
  logic [1:0]   State;
  logic [3:0]   Count, Remain;
`ifdef TRACE_CMP_TRIG_EN
  logic [7:0]   TrigValue;
`endif

  int checks   = 0;
  int failures = 0;

  cpu_trace_buffer #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Arm(Arm), .SampleEn(SampleEn),
    .ChIn(ChIn), .Trig(Trig),
`ifdef TRACE_CMP_TRIG_EN
    .TrigValue(TrigValue),
`endif
    .RdEn(RdEn), .RdData(RdData), .RdValid(RdValid), .State(State),
    .Done(Done), .Wrapped(Wrapped), .Count(Count), .Remain(Remain)
  );

  always #5 Clock = ~Clock;

  // Reference model: stored samples oldest-first, plus a queue of unread entries
  int           m_state;
  logic [W-1:0] m_buf[$];
  logic [W-1:0] m_unread[$];
  int           m_post;
  bit           m_wrapped;
  bit           m_valid;
  logic [W-1:0] m_rddata;

  typedef struct {
    bit         rst, arm, se;
    logic [7:0] n;
    bit         trig, rden;
    logic [1:0] e_state;
    int         e_count;
    bit         e_done, e_wrap, e_valid;
    logic [7:0] e_byte;
    int         e_remain;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [W-1:0] rep(input logic [7:0] n);
    return {NUM_CH{n}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit arm, input bit se,
                            input logic [W-1:0] din, input bit trig, input bit rden);
    bit hit;
    hit = trig;
`ifdef TRACE_CMP_TRIG_EN
    if (din[7:0] == TrigValue) hit = 1'b1;
`endif
    m_valid = 1'b0;
    if (rst) begin
      m_state = 0; m_buf.delete(); m_unread.delete();
      m_wrapped = 1'b0; m_rddata = '0; m_post = 0;
    end else if (arm) begin
      m_state = 1; m_buf.delete(); m_unread.delete(); m_wrapped = 1'b0;
    end else if ((m_state == 1 || m_state == 2) && se) begin
      if (m_state == 1 && m_buf.size() == DEPTH) m_wrapped = 1'b1;
      m_buf.push_back(din);
      if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
      if (m_state == 1) begin
        if (hit) begin
          if (POST_TRIG == 0) begin
            m_state = 3; m_unread = m_buf;
          end else begin
            m_state = 2; m_post = POST_TRIG;
          end
        end
      end else begin
        m_post--;
        if (m_post == 0) begin
          m_state = 3; m_unread = m_buf;
        end
      end
    end else if (m_state == 3 && rden && m_unread.size() > 0) begin
      m_rddata = m_unread.pop_front();
      m_valid  = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("model_state",   64'(State),   64'(m_state));
    chk("model_done",    64'(Done),    64'(m_state == 3));
    chk("model_wrapped", 64'(Wrapped), 64'(m_wrapped));
    chk("model_count",   64'(Count),   64'(m_buf.size()));
    chk("model_remain",  64'(Remain),  64'(m_unread.size()));
    chk("model_rdvalid", 64'(RdValid), 64'(m_valid));
    chk("model_rddata",  64'(RdData),  64'(m_rddata));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge
  task automatic step(input bit rst, input bit arm, input bit se,
                      input logic [W-1:0] din, input bit trig, input bit rden);
    Reset = rst; Arm = arm; SampleEn = se; ChIn = din; Trig = trig; RdEn = rden;
    @(posedge Clock);
    model_step(rst, arm, se, din, trig, rden);
    @(negedge Clock);
    check_model();
  endtask

  task automatic add(input bit rst, input bit arm, input bit se, input logic [7:0] n,
                     input bit trig, input bit rden, input logic [1:0] st, input int cnt,
                     input bit dn, input bit wr, input bit v, input logic [7:0] b, input int rem);
    vec_t r;
    r.rst = rst; r.arm = arm; r.se = se; r.n = n; r.trig = trig; r.rden = rden;
    r.e_state = st; r.e_count = cnt; r.e_done = dn; r.e_wrap = wr;
    r.e_valid = v; r.e_byte = b; r.e_remain = rem;
    tbl.push_back(r);
  endtask

  initial begin
    Reset = 1'b1; Arm = 1'b0; SampleEn = 1'b0; ChIn = '0; Trig = 1'b0; RdEn = 1'b0;
`ifdef TRACE_CMP_TRIG_EN
    TrigValue = 8'h2A;
`endif
    m_state = 0; m_post = 0; m_wrapped = 1'b0; m_valid = 1'b0; m_rddata = '0;

    // Reset for two cycles, then a plain capture with trigger on sample 5 and full readout
    add(1'b1,1'b0,1'b0,8'd0,1'b0,1'b0, 2'd0,0,1'b0,1'b0,1'b0,8'd0,0);
    add(1'b1,1'b0,1'b0,8'd0,1'b0,1'b0, 2'd0,0,1'b0,1'b0,1'b0,8'd0,0);
    add(1'b0,1'b1,1'b0,8'd0,1'b0,1'b0, 2'd1,0,1'b0,1'b0,1'b0,8'd0,0);
    for (int n = 1; n <= 4; n++)
      add(1'b0,1'b0,1'b1,8'(n),1'b0,1'b0, 2'd1,n,1'b0,1'b0,1'b0,8'd0,0);
    add(1'b0,1'b0,1'b1,8'd5,1'b1,1'b0, 2'd2,5,1'b0,1'b0,1'b0,8'd0,0);
    add(1'b0,1'b0,1'b1,8'd6,1'b0,1'b0, 2'd2,6,1'b0,1'b0,1'b0,8'd0,0);
    add(1'b0,1'b0,1'b1,8'd7,1'b0,1'b0, 2'd2,7,1'b0,1'b0,1'b0,8'd0,0);
    add(1'b0,1'b0,1'b1,8'd8,1'b0,1'b0, 2'd3,8,1'b1,1'b0,1'b0,8'd0,8);
    for (int i = 1; i <= 8; i++)
      add(1'b0,1'b0,1'b0,8'd0,1'b0,1'b1, 2'd3,8,1'b1,1'b0,1'b1,8'(i),8-i);
    add(1'b0,1'b0,1'b0,8'd0,1'b0,1'b1, 2'd3,8,1'b1,1'b0,1'b0,8'd8,0);
    // Arm together with a triggering sample and a read: all ignored
    add(1'b0,1'b1,1'b1,8'd9,1'b1,1'b1, 2'd1,0,1'b0,1'b0,1'b0,8'd8,0);
    add(1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 2'd1,0,1'b0,1'b0,1'b0,8'd8,0);

    @(negedge Clock);
    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].arm, tbl[k].se, rep(tbl[k].n), tbl[k].trig, tbl[k].rden);
      chk("tbl_state",   64'(State),   64'(tbl[k].e_state));
      chk("tbl_count",   64'(Count),   64'(tbl[k].e_count));
      chk("tbl_done",    64'(Done),    64'(tbl[k].e_done));
      chk("tbl_wrapped", 64'(Wrapped), 64'(tbl[k].e_wrap));
      chk("tbl_rdvalid", 64'(RdValid), 64'(tbl[k].e_valid));
      chk("tbl_rddata",  64'(RdData),  64'(rep(tbl[k].e_byte)));
      chk("tbl_remain",  64'(Remain),  64'(tbl[k].e_remain));
    end

    // Long pre-trigger run that wraps the buffer; readout must give 16..23
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int n = 1; n <= 23; n++)
      step(1'b0, 1'b0, 1'b1, rep(8'(n)), (n == 20), 1'b0);
    chk("wrap_state",   64'(State),   64'(2'd3));
    chk("wrap_count",   64'(Count),   64'(8));
    chk("wrap_flag",    64'(Wrapped), 64'(1'b1));
    chk("wrap_remain",  64'(Remain),  64'(8));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("wrap_rd_valid", 64'(RdValid), 64'(1'b1));
      chk("wrap_rd_data",  64'(RdData),  64'(rep(8'(16 + i))));
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("ninth_rd_valid", 64'(RdValid), 64'(1'b0));
    chk("ninth_rd_hold",  64'(RdData),  64'(rep(8'd23)));

    // Reset in the middle of the post-trigger phase
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, rep(8'd1), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, rep(8'd2), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, rep(8'd3), 1'b0, 1'b0);
    chk("post_state", 64'(State), 64'(2'd2));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_post_state",  64'(State),  64'(2'd0));
    chk("rst_post_count",  64'(Count),  64'(0));
    chk("rst_post_rddata", 64'(RdData), 64'(0));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_post_rdvalid", 64'(RdValid), 64'(1'b0));

`ifdef TRACE_CMP_TRIG_EN
    // Channel-0 value compare acts as a trigger without Trig
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    TrigValue = 8'h2A;
    step(1'b0, 1'b0, 1'b1, {8'h11, 8'h22, 8'h33, 8'h2A}, 1'b0, 1'b0);
    chk("cmp_trig_state", 64'(State), 64'(2'd2));
`endif

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
`ifdef TRACE_CMP_TRIG_EN
      TrigValue = 8'($urandom_range(0, 255));
`endif
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6), W'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 8, meaning width of one observed channel (register) in bits.
REQ-002 Parameter NUM_CH, default 4, meaning number of channels captured per sample.
REQ-003 Parameter DEPTH, default 16, meaning sample entries in the buffer; the value SHALL be a power of two and at least 2.
REQ-004 Parameter POST_TRIG, default 8, meaning samples captured after the trigger sample; the range SHALL be 0..DEPTH-1.
REQ-005 Clock  input  1  rising-edge clock.
REQ-006 Reset  input  1  reset, synchronous, active-high.
REQ-007 Arm  input  1  pulse; clears the buffer and starts capture.
REQ-008 SampleEn  input  1  qualifies ChIn as a sample this cycle.
REQ-009 ChIn  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 Trig  input  1  external trigger, sampled only with SampleEn.
REQ-011 RdEn  input  1  requests the next stored sample.
REQ-012 RdData  output  NUM_CH*DATA_W  readout sample.
REQ-013 RdValid  output  1  RdData valid, one-cycle pulse per read.
REQ-014 State  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-015 Done  output  1  high in DONE.
REQ-016 Wrapped  output  1  pre-trigger data overwritten.
REQ-017 Count  output  clog2(DEPTH)+1  valid entries, saturating at DEPTH.
REQ-018 Remain  output  clog2(DEPTH)+1  entries not yet read in DONE.

Function
REQ-019 Arm in any state SHALL enter ARMED next cycle with write pointer, Count, Remain and Wrapped cleared; a sample, Trig or RdEn in the Arm cycle SHALL be ignored.
REQ-020 In ARMED or POST, SampleEn=1 SHALL write ChIn at the write pointer and advance it modulo DEPTH; Count SHALL increment to at most DEPTH.
REQ-021 A write in ARMED with Count already equal to DEPTH SHALL set Wrapped; Wrapped SHALL stay set until the next Arm or Reset.
REQ-022 In ARMED, SampleEn=1 with Trig=1 SHALL store that sample as the trigger sample and go to POST with the post counter set to POST_TRIG; with POST_TRIG=0 the block SHALL go directly to DONE.
REQ-023 In POST, each sample SHALL decrement the post counter; the sample that takes it to 0 SHALL be written, and the block SHALL enter DONE next cycle; Trig SHALL be ignored in POST.
REQ-024 On entry to DONE, the read pointer SHALL be set to the oldest entry, (write pointer - Count) mod DEPTH, and Remain SHALL be set to Count.
REQ-025 In DONE, RdEn=1 with Remain>0 SHALL give RdValid=1 and RdData = oldest unread entry on the next cycle (latency 1), then advance the read pointer and decrement Remain.
REQ-026 RdEn when Remain=0 or outside DONE SHALL be ignored, with RdValid=0 and RdData holding its value.
REQ-027 Samples SHALL NOT be written in IDLE or DONE.
REQ-028 Back-to-back RdEn SHALL sustain one sample per cycle.

Reset
REQ-029 Reset SHALL take priority over Arm and all other inputs.
REQ-030 Reset, including mid-capture or mid-readout, SHALL give State=IDLE and set Done, Wrapped, Count, Remain, RdValid and RdData to 0 on the next edge.
REQ-031 Buffer RAM contents SHALL NOT be reset.

Configuration
REQ-032 Macro TRACE_CMP_TRIG_EN: when defined, added input TrigValue (DATA_W) SHALL act as a trigger when channel 0 of a sample equals TrigValue, ORed with Trig.
REQ-033 Without TRACE_CMP_TRIG_EN, the TrigValue port SHALL be absent and only Trig SHALL trigger.

Structure
REQ-034 Package cpu_trace_pkg SHALL hold the state enum and encodings, and a pointer-width function.
REQ-035 Sub-module trace_ram SHALL be a simple dual-port RAM, DEPTH x NUM_CH*DATA_W, with one write port and a registered read port giving 1-cycle latency.

Verification (DEPTH=8, POST_TRIG=3, DATA_W=8, NUM_CH=4; sample n = all channels equal to n)
REQ-036 Reset asserted for 2 cycles -> State=0, Done=0, Count=0, RdValid=0.
REQ-037 Arm; samples 1..5 with Trig on 5; samples 6..8 -> Done=1, Count=8, Wrapped=0; 8 RdEn cycles read 1..8 in order, then Remain=0.
REQ-038 Arm; samples 1..20 with Trig on 20; samples 21..23 -> Count=8, Wrapped=1; readout gives 16..23; a ninth RdEn gives RdValid=0.
REQ-039 Arm asserted together with SampleEn=1 and Trig=1 -> State=ARMED, Count=0, no trigger taken.
REQ-040 Reset during POST after 1 post sample -> State=IDLE, Count=0; a following RdEn gives RdValid=0.
REQ-041 With TRACE_CMP_TRIG_EN, TrigValue=8'h2A, Trig=0, sample with channel 0 = 8'h2A -> State=POST on the next cycle.
